// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, persistent NZCV flags and an
// iterative shift-add multiplier (one multiplier bit per cycle).
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [2:0]       Aluop,
  input  logic             Sel,
  input  logic [WIDTH-1:0] DatA,
  input  logic [WIDTH-1:0] DatB,
  output logic [WIDTH-1:0] Rslt,
  output logic             Out_valid,
  output logic             Zero,
  output logic             Neg,
  output logic             Carry,
  output logic             Ovf
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);

  localparam logic [2:0] OP_CMP   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_NEG   = 3'b100;
  localparam logic [2:0] OP_SHIFT = 3'b101;
  localparam logic [2:0] OP_LOGIC = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             is_mul;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] op_res;
  logic             op_c;
  logic             op_v;
  logic             wr_rslt;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;

  assign accept   = In_valid && (state == IDLE);
  assign is_mul   = MUL_EN && (Aluop == OP_MUL);
  assign sum_w    = {1'b0, DatA} + {1'b0, DatB};
  assign diff_w   = {1'b0, DatA} - {1'b0, DatB};
  assign amt      = DatB[SHW-1:0];
  assign mul_step = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    In_ready  = 1'b0;
    case (state)
      IDLE: begin
        In_ready = 1'b1;
        if (In_valid && is_mul) begin
          state_nxt = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (cnt == LAST_CNT) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle result and flag candidates; C/V default to holding their value.
  always_comb begin
    op_res  = DatB;
    op_c    = Carry;
    op_v    = Ovf;
    wr_rslt = 1'b1;
    case (Aluop)
      OP_CMP: begin
        op_res  = diff_w[WIDTH-1:0];
        op_c    = ~diff_w[WIDTH];
        op_v    = (DatA[WIDTH-1] ^ DatB[WIDTH-1]) & (diff_w[WIDTH-1] ^ DatA[WIDTH-1]);
        wr_rslt = 1'b0;
      end
      OP_ADD: begin
        op_res = sum_w[WIDTH-1:0];
        op_c   = sum_w[WIDTH];
        op_v   = ~(DatA[WIDTH-1] ^ DatB[WIDTH-1]) & (sum_w[WIDTH-1] ^ DatA[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = diff_w[WIDTH-1:0];
        op_c   = ~diff_w[WIDTH];
        op_v   = (DatA[WIDTH-1] ^ DatB[WIDTH-1]) & (diff_w[WIDTH-1] ^ DatA[WIDTH-1]);
      end
      OP_NEG: begin
        op_res = '0 - DatA;
        op_c   = (DatA == '0);
        op_v   = (DatA == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_SHIFT: op_res = Sel ? (DatA >> amt) : (DatA << amt);
      OP_LOGIC: op_res = Sel ? (DatA | DatB) : (DatA & DatB);
      default:  op_res = DatB;
    endcase
  end

  // The final multiplier iteration and the result/flag write share one edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Rslt      <= '0;
      Zero      <= 1'b0;
      Neg       <= 1'b0;
      Carry     <= 1'b0;
      Ovf       <= 1'b0;
      Out_valid <= 1'b0;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      Out_valid <= 1'b0;
      if (accept) begin
        if (is_mul) begin
          mcand  <= {{WIDTH{1'b0}}, DatA};
          mplier <= DatB;
          acc    <= '0;
          cnt    <= '0;
        end else begin
          if (wr_rslt) begin
            Rslt <= op_res;
          end
          Zero      <= (op_res == '0);
          Neg       <= op_res[WIDTH-1];
          Carry     <= op_c;
          Ovf       <= op_v;
          Out_valid <= 1'b1;
        end
      end else if (state == MUL_BUSY) begin
        acc    <= mul_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == LAST_CNT) begin
          Rslt      <= mul_step[WIDTH-1:0];
          Zero      <= (mul_step[WIDTH-1:0] == '0);
          Neg       <= mul_step[WIDTH-1];
          Carry     <= |mul_step[2*WIDTH-1:WIDTH];
          Ovf       <= 1'b0;
          Out_valid <= 1'b1;
          cnt       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: an 8-bit instance checked against a small
// integer model, plus a 16-bit instance used for the wide multiply.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, sel, out_valid, zero, neg, carry, ovf;
  logic [2:0] aluop;
  logic [7:0] dat_a, dat_b, rslt;

  logic        w_in_valid, w_in_ready, w_sel, w_out_valid, w_zero, w_neg, w_carry, w_ovf;
  logic [2:0]  w_aluop;
  logic [15:0] w_dat_a, w_dat_b, w_rslt;

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
    .Clk(clk), .Reset_n(rst_n), .In_valid(in_valid), .In_ready(in_ready),
    .Aluop(aluop), .Sel(sel), .DatA(dat_a), .DatB(dat_b), .Rslt(rslt),
    .Out_valid(out_valid), .Zero(zero), .Neg(neg), .Carry(carry), .Ovf(ovf)
  );

  alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut16 (
    .Clk(clk), .Reset_n(rst_n), .In_valid(w_in_valid), .In_ready(w_in_ready),
    .Aluop(w_aluop), .Sel(w_sel), .DatA(w_dat_a), .DatB(w_dat_b), .Rslt(w_rslt),
    .Out_valid(w_out_valid), .Zero(w_zero), .Neg(w_neg), .Carry(w_carry), .Ovf(w_ovf)
  );

  localparam logic [2:0] MOV = 3'b000, CMP = 3'b001, ADD = 3'b010, SUB = 3'b011;
  localparam logic [2:0] NEG = 3'b100, SHF = 3'b101, LOG = 3'b110, MUL = 3'b111;

  typedef struct {
    logic [7:0] rslt;
    logic       z, n, c, v;
    int         tag;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   tag_cnt = 0;

  logic [7:0] m_rslt;
  logic       m_z, m_n, m_c, m_v;

  // Reference model working in plain integers; C/V and Rslt hold as the ALU defines.
  task automatic model_push(input logic [2:0] op, input logic s, input logic [7:0] a, input logic [7:0] b);
    int   ia, ib, sa, sb, full, r, sres, amt;
    exp_t e;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    r  = int'(m_rslt);
    case (op)
      ADD: begin
        full = ia + ib; r = full % 256; m_c = (full >= 256);
        sres = sa + sb; m_v = (sres > 127) || (sres < -128);
      end
      SUB, CMP: begin
        full = ia - ib; r = (full + 256) % 256; m_c = (ia >= ib);
        sres = sa - sb; m_v = (sres > 127) || (sres < -128);
      end
      NEG: begin
        r = (256 - ia) % 256; m_c = (ia == 0); m_v = (ia == 128);
      end
      SHF: begin
        amt = ib % 8;
        r = s ? (ia >> amt) : ((ia << amt) % 256);
      end
      LOG: r = s ? (ia | ib) : (ia & ib);
      MUL: begin
        full = ia * ib; r = full % 256; m_c = (full >= 256); m_v = 1'b0;
      end
      default: r = ib;
    endcase
    m_z = (r == 0);
    m_n = (r >= 128);
    if (op != CMP) m_rslt = 8'(r);
    e.rslt = m_rslt; e.z = m_z; e.n = m_n; e.c = m_c; e.v = m_v;
    e.tag  = tag_cnt;
    tag_cnt++;
    sb_q.push_back(e);
  endtask

  task automatic model_reset();
    m_rslt = 8'd0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
    sb_q.delete();
  endtask

  // Pops one expectation per completion pulse of the 8-bit instance.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_out_valid: got Rslt=%0d with no pending operation", rslt);
      end else begin
        e = sb_q.pop_front();
        if ({rslt, zero, neg, carry, ovf} !== {e.rslt, e.z, e.n, e.c, e.v}) begin
          errors++;
          $display("[TB] FAIL scoreboard_op%0d: got Rslt=%0d ZNCV=%b%b%b%b, want Rslt=%0d ZNCV=%b%b%b%b",
                   e.tag, rslt, zero, neg, carry, ovf, e.rslt, e.z, e.n, e.c, e.v);
        end
      end
    end
  end

  // Called at a falling edge; the operation is taken at the next rising edge.
  task automatic issue(input logic [2:0] op, input logic s, input logic [7:0] a, input logic [7:0] b);
    aluop = op; sel = s; dat_a = a; dat_b = b; in_valid = 1'b1;
    model_push(op, s, a, b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending results, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    in_valid = 1'b0; aluop = MOV; sel = 1'b0; dat_a = 8'd0; dat_b = 8'd0;
    w_in_valid = 1'b0; w_aluop = MOV; w_sel = 1'b0; w_dat_a = 16'd0; w_dat_b = 16'd0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rslt !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_rslt: got %0d, want 0", rslt);
    end
    checks++;
    if ({zero, neg, carry, ovf} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_flags: got ZNCV=%b%b%b%b, want 0000", zero, neg, carry, ovf);
    end
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("[TB] FAIL reset_handshake: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    checks++;
    if ({w_rslt, w_out_valid, w_in_ready} !== {16'd0, 2'b01}) begin
      errors++; $display("[TB] FAIL reset_wide: got Rslt=%0d out_valid=%b in_ready=%b, want 0 0 1", w_rslt, w_out_valid, w_in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int run = 0;
    issue(ADD, 1'b0, 8'd200, 8'd100);
    if (out_valid === 1'b1) run++;
    checks++;
    if ({rslt, carry, ovf} !== {8'd44, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL add_carry: got Rslt=%0d C=%b V=%b, want 44 1 0", rslt, carry, ovf);
    end
    issue(ADD, 1'b0, 8'd100, 8'd100);
    if (out_valid === 1'b1) run++;
    checks++;
    if ({rslt, neg, ovf, carry} !== {8'd200, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL add_ovf: got Rslt=%0d N=%b V=%b C=%b, want 200 1 1 0", rslt, neg, ovf, carry);
    end
    issue(SUB, 1'b0, 8'd5, 8'd15);
    if (out_valid === 1'b1) run++;
    checks++;
    if ({rslt, neg, carry} !== {8'd246, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL sub_borrow: got Rslt=%0d N=%b C=%b, want 246 1 0", rslt, neg, carry);
    end
    checks++;
    if (run != 3) begin
      errors++; $display("[TB] FAIL b2b_pulses: got %0d consecutive, want 3", run);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_idle: got out_valid=%b, want 0", out_valid);
    end
    drain();
  endtask

  task automatic test_cmp_mov();
    issue(ADD, 1'b0, 8'd200, 8'd100);
    issue(CMP, 1'b0, 8'd20, 8'd20);
    checks++;
    if ({rslt, zero, carry, neg, ovf} !== {8'd44, 4'b1100}) begin
      errors++; $display("[TB] FAIL cmp_hold: got Rslt=%0d ZCNV=%b%b%b%b, want 44 1100", rslt, zero, carry, neg, ovf);
    end
    issue(MOV, 1'b0, 8'd77, 8'd0);
    checks++;
    if ({rslt, zero, carry} !== {8'd0, 2'b11}) begin
      errors++; $display("[TB] FAIL mov_zero: got Rslt=%0d Z=%b C=%b, want 0 1 1", rslt, zero, carry);
    end
    drain();
  endtask

  task automatic test_shift_logic();
    issue(SHF, 1'b0, 8'd4, 8'd2);
    checks++;
    if (rslt !== 8'd16) begin errors++; $display("[TB] FAIL lsl: got %0d, want 16", rslt); end
    issue(SHF, 1'b1, 8'd16, 8'd1);
    checks++;
    if (rslt !== 8'd8) begin errors++; $display("[TB] FAIL lsr: got %0d, want 8", rslt); end
    issue(SHF, 1'b0, 8'd1, 8'd9);
    checks++;
    if (rslt !== 8'd2) begin errors++; $display("[TB] FAIL lsl_amt_wrap: got %0d, want 2", rslt); end
    issue(SHF, 1'b0, 8'h5A, 8'd8);
    checks++;
    if (rslt !== 8'h5A) begin errors++; $display("[TB] FAIL lsl_amt0: got %0h, want 5a", rslt); end
    issue(LOG, 1'b0, 8'hAA, 8'hCC);
    checks++;
    if (rslt !== 8'h88) begin errors++; $display("[TB] FAIL and: got %0h, want 88", rslt); end
    issue(LOG, 1'b1, 8'hAA, 8'hCC);
    checks++;
    if ({rslt, neg} !== {8'hEE, 1'b1}) begin
      errors++; $display("[TB] FAIL orr: got %0h N=%b, want ee 1", rslt, neg);
    end
    issue(NEG, 1'b0, 8'h80, 8'd0);
    checks++;
    if ({rslt, ovf, neg, carry} !== {8'h80, 3'b110}) begin
      errors++; $display("[TB] FAIL neg_min: got %0h V=%b N=%b C=%b, want 80 1 1 0", rslt, ovf, neg, carry);
    end
    drain();
  endtask

  task automatic test_mul();
    int n;
    logic [7:0] held;
    held = rslt;
    issue(MUL, 1'b0, 8'd13, 8'd11);
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if ({in_ready, out_valid, rslt} !== {2'b00, held}) begin
        errors++;
        $display("[TB] FAIL mul_busy_c%0d: got in_ready=%b out_valid=%b Rslt=%0d, want 0 0 %0d",
                 k, in_ready, out_valid, rslt, held);
      end
      if (k == 3) begin
        aluop = ADD; dat_a = 8'd1; dat_b = 8'd1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if ({out_valid, in_ready, rslt, carry} !== {2'b11, 8'd143, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mul_13x11: got out_valid=%b in_ready=%b Rslt=%0d C=%b, want 1 1 143 0",
               out_valid, in_ready, rslt, carry);
    end
    issue(MUL, 1'b0, 8'd20, 8'd20);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({n[7:0], rslt, carry} !== {8'd8, 8'd144, 1'b1}) begin
      errors++; $display("[TB] FAIL mul_20x20: got wait=%0d Rslt=%0d C=%b, want 8 144 1", n, rslt, carry);
    end
    drain();
  endtask

  task automatic test_mul_wide();
    int n = 0;
    w_aluop = MUL; w_sel = 1'b0; w_dat_a = 16'd300; w_dat_b = 16'd300; w_in_valid = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0;
    while (w_out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({w_out_valid, w_rslt, w_carry, w_ovf, w_zero, w_neg} !== {1'b1, 16'd24464, 4'b1000}) begin
      errors++;
      $display("[TB] FAIL mul_wide: got valid=%b Rslt=%0d CVZN=%b%b%b%b, want 1 24464 1000",
               w_out_valid, w_rslt, w_carry, w_ovf, w_zero, w_neg);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    issue(MUL, 1'b0, 8'd7, 8'd9);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({rslt, zero, neg, carry, ovf, out_valid, in_ready} !== {8'd0, 6'b000001}) begin
      errors++;
      $display("[TB] FAIL reset_mid_mul: got Rslt=%0d ZNCV=%b%b%b%b out_valid=%b in_ready=%b, want 0 0000 0 1",
               rslt, zero, neg, carry, ovf, out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++; $display("[TB] FAIL post_abort_c%0d: got out_valid=%b in_ready=%b, want 0 1", k, out_valid, in_ready);
      end
      @(negedge clk);
    end
    issue(ADD, 1'b0, 8'd1, 8'd1);
    checks++;
    if ({out_valid, rslt} !== {1'b1, 8'd2}) begin
      errors++; $display("[TB] FAIL add_after_abort: got out_valid=%b Rslt=%0d, want 1 2", out_valid, rslt);
    end
    drain();
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_cmp_mov();
    test_shift_logic();
    test_mul();
    test_mul_wide();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
